// File: rtl/uart_apb_master.sv
// -----------------------------------------------------------------------------
// uart_apb_master
//
// Turns framed command bytes from a UART receiver into single APB transfers
// and returns a short response over the UART transmitter.
//
//   Write frame : 'W'(0x57) ADDR_LO ADDR_HI D0 D1 D2 D3   (data LSB first)
//   Read frame  : 'R'(0x52) ADDR_LO ADDR_HI
//   Response    : 'E'(0x45) on slave error, 'K'(0x4B) on write success,
//                 or the 4 read-data bytes LSB first.
//
// Ports
//   clk_apb, rst_apb_n        : clock, asynchronous active-low reset
//   rx_valid, rx_data         : received byte strobe (no backpressure)
//   tx_valid, tx_data,tx_ready: response byte stream (valid/ready)
//   apb_uart_* / uart_apb_*   : APB requester side (psel/penable/paddr/
//                               pwrite/pwdata out, prdata/pready/pslverr in)
//   busy                      : high whenever the FSM is not IDLE
//   frame_err                 : one-cycle pulse when a frame times out
//   rx_drop                   : one-cycle pulse when a byte is discarded
//   dbg_state_o               : current FSM state, for observation only
//
// Handshake semantics: a tx byte transfers on any rising edge where
// tx_valid=1 and tx_ready=1; tx_data is held until that edge and the next
// byte (if any) appears the following cycle. The rx side has no ready: a
// byte exists only in the cycle rx_valid=1. APB follows the usual
// SETUP (psel=1, penable=0) then ACCESS (psel=1, penable=1 until pready=1).
// -----------------------------------------------------------------------------
module uart_apb_master #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
   input  logic        clk_apb,
   input  logic        rst_apb_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        apb_uart_psel,
   output logic [11:0] apb_uart_paddr,
   output logic        apb_uart_penable,
   output logic        apb_uart_pwrite,
   output logic [31:0] apb_uart_pwdata,
   input  logic [31:0] uart_apb_prdata,
   input  logic        uart_apb_pready,
   input  logic        uart_apb_pslverr,
   output logic        busy,
   output logic        frame_err,
   output logic        rx_drop,
   output logic [2:0]  dbg_state_o
);

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RESP_ERR  = 8'h45;
   localparam logic [7:0] RESP_OK   = 8'h4B;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR0  = 3'd1,
      S_ADDR1  = 3'd2,
      S_DATA   = 3'd3,
      S_SETUP  = 3'd4,
      S_ACCESS = 3'd5,
      S_RESP   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic        is_write_q, is_write_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   // Byte index: data byte while collecting D0..D3, response byte in RESP.
   logic [1:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;

   logic in_frame;
   logic apb_phase;
   logic timeout;
   logic last_resp;

   always_ff @(posedge clk_apb or negedge rst_apb_n) begin
      if (!rst_apb_n) begin
         state_q    <= S_IDLE;
         is_write_q <= 1'b0;
         addr_q     <= 12'h0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         err_q      <= 1'b0;
         idx_q      <= 2'd0;
         cnt_q      <= 16'h0;
      end else begin
         state_q    <= state_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      in_frame  = (state_q == S_ADDR0) || (state_q == S_ADDR1) || (state_q == S_DATA);
      apb_phase = (state_q == S_SETUP) || (state_q == S_ACCESS);
      // The counter reaches TIMEOUT_CYCLES on this edge; a byte arriving in
      // the same cycle wins and the frame carries on.
      timeout   = in_frame && !rx_valid && (cnt_q == TIMEOUT_CYCLES - 16'd1);
      // Error and write responses are a single byte; reads return four.
      last_resp = err_q || is_write_q || (idx_q == 2'd3);
   end

   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      idx_d      = idx_q;
      cnt_d      = 16'h0;
      frame_err  = 1'b0;

      if (in_frame) begin
         cnt_d = rx_valid ? 16'h0 : cnt_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
               state_d    = S_ADDR0;
               is_write_d = (rx_data == CMD_WRITE);
               addr_d     = 12'h0;
               wdata_d    = 32'h0;
               rdata_d    = 32'h0;
               err_d      = 1'b0;
               idx_d      = 2'd0;
            end
         end
         S_ADDR0: begin
            if (rx_valid) begin
               addr_d[7:0] = rx_data;
               state_d     = S_ADDR1;
            end else if (timeout) begin
               state_d   = S_IDLE;
               cnt_d     = 16'h0;
               frame_err = 1'b1;
            end
         end
         S_ADDR1: begin
            if (rx_valid) begin
               // Upper nibble of ADDR_HI is outside the 12-bit APB space.
               addr_d[11:8] = rx_data[3:0];
               idx_d        = 2'd0;
               state_d      = is_write_q ? S_DATA : S_SETUP;
            end else if (timeout) begin
               state_d   = S_IDLE;
               cnt_d     = 16'h0;
               frame_err = 1'b1;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = S_SETUP;
               end
            end else if (timeout) begin
               state_d   = S_IDLE;
               cnt_d     = 16'h0;
               frame_err = 1'b1;
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (uart_apb_pready) begin
               if (!is_write_q) begin
                  rdata_d = uart_apb_prdata;
               end
               err_d   = uart_apb_pslverr;
               idx_d   = 2'd0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (tx_ready) begin
               if (last_resp) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode straight from registered state, so an asynchronous reset
   // silences the APB and tx sides in the same instant.
   always_comb begin
      apb_uart_psel    = apb_phase;
      apb_uart_penable = (state_q == S_ACCESS);
      apb_uart_pwrite  = apb_phase && is_write_q;
      apb_uart_paddr   = apb_phase ? addr_q : 12'h0;
      apb_uart_pwdata  = (apb_phase && is_write_q) ? wdata_q : 32'h0;

      tx_valid = (state_q == S_RESP);
      tx_data  = 8'h0;
      if (state_q == S_RESP) begin
         if (err_q) begin
            tx_data = RESP_ERR;
         end else if (is_write_q) begin
            tx_data = RESP_OK;
         end else begin
            tx_data = rdata_q[{idx_q, 3'b000} +: 8];
         end
      end

      busy        = (state_q != S_IDLE);
      // Includes the RESP->IDLE cycle: that byte is never decoded.
      rx_drop     = rx_valid && (apb_phase || (state_q == S_RESP));
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_uart_apb_master.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_master
//
// Drives UART frames into uart_apb_master, plays the APB slave and the UART
// transmitter, and compares every observable against a transaction-level
// model: expected APB address/write/data derived from the frame fields and
// an expected response-byte queue derived from the slave's reply.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_uart_apb_master;

   localparam int TO = 16;

   logic        clk_apb = 1'b0;
   logic        rst_apb_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        apb_uart_psel;
   logic [11:0] apb_uart_paddr;
   logic        apb_uart_penable;
   logic        apb_uart_pwrite;
   logic [31:0] apb_uart_pwdata;
   logic [31:0] uart_apb_prdata;
   logic        uart_apb_pready;
   logic        uart_apb_pslverr;
   logic        busy;
   logic        frame_err;
   logic        rx_drop;
   logic [2:0]  dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   uart_apb_master #(.TIMEOUT_CYCLES(16'd16)) dut (
      .clk_apb          (clk_apb),
      .rst_apb_n        (rst_apb_n),
      .rx_valid         (rx_valid),
      .rx_data          (rx_data),
      .tx_valid         (tx_valid),
      .tx_data          (tx_data),
      .tx_ready         (tx_ready),
      .apb_uart_psel    (apb_uart_psel),
      .apb_uart_paddr   (apb_uart_paddr),
      .apb_uart_penable (apb_uart_penable),
      .apb_uart_pwrite  (apb_uart_pwrite),
      .apb_uart_pwdata  (apb_uart_pwdata),
      .uart_apb_prdata  (uart_apb_prdata),
      .uart_apb_pready  (uart_apb_pready),
      .uart_apb_pslverr (uart_apb_pslverr),
      .busy             (busy),
      .frame_err        (frame_err),
      .rx_drop          (rx_drop),
      .dbg_state_o      (dbg_state)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk_apb = ~clk_apb;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- checker
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_apb);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_apb);
   endtask

   // ---------------------------------------------------------------- drivers
   // gap idle cycles, then one strobed byte.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         sample();
         check("gap_frame_err", frame_err, 1'b0);
         check("gap_psel", apb_uart_psel, 1'b0);
         step();
      end
      rx_valid = 1'b1;
      rx_data  = b;
      sample();
      check("byte_rx_drop", rx_drop, 1'b0);
      check("byte_frame_err", frame_err, 1'b0);
      step();
      rx_valid = 1'b0;
   endtask

   // One full transaction. drop_at: 0 none, 1 byte in SETUP, 2 byte in first
   // ACCESS cycle, 3 byte in first RESP cycle, 4 'W' on the final handshake.
   // long_gap_idx: frame byte preceded by TO-1 idle cycles (edge of timeout).
   task automatic run_txn(input bit is_wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int waits, input bit err,
                          input int hold, input int drop_at, input int long_gap_idx);
      logic [7:0]  bytes[$];
      logic [11:0] e_addr;
      logic [31:0] e_wdata;
      int          cyc;
      int          hold_left;
      bit          drv;

      e_addr  = {addr[11:8], addr[7:0]};
      e_wdata = is_wr ? data : 32'h0;
      bytes.push_back(is_wr ? 8'h57 : 8'h52);
      bytes.push_back(addr[7:0]);
      bytes.push_back(addr[15:8]);
      if (is_wr) begin
         for (int i = 0; i < 4; i++) bytes.push_back(data[8*i +: 8]);
      end
      exp_q.delete();
      if (err)        exp_q.push_back(8'h45);
      else if (is_wr) exp_q.push_back(8'h4B);
      else for (int i = 0; i < 4; i++) exp_q.push_back(rdata[8*i +: 8]);

      for (int i = 0; i < bytes.size(); i++) begin
         send_byte(bytes[i], (i == long_gap_idx) ? TO - 1 : int'($urandom_range(0, 3)));
      end

      // SETUP: the cycle right after the final frame byte.
      rx_valid = (drop_at == 1);
      rx_data  = 8'($urandom);
      sample();
      check("setup_psel", apb_uart_psel, 1'b1);
      check("setup_penable", apb_uart_penable, 1'b0);
      check("setup_paddr", apb_uart_paddr, e_addr);
      check("setup_pwrite", apb_uart_pwrite, is_wr);
      check("setup_pwdata", apb_uart_pwdata, e_wdata);
      check("setup_rx_drop", rx_drop, drop_at == 1);
      step();

      // ACCESS: waits cycles with pready low, then the completing cycle.
      for (int w = 0; w <= waits; w++) begin
         uart_apb_pready  = (w == waits);
         uart_apb_prdata  = (w == waits) ? rdata : $urandom;
         uart_apb_pslverr = (w == waits) ? err : 1'($urandom_range(0, 1));
         rx_valid         = (drop_at == 2) && (w == 0);
         rx_data          = 8'h52;
         sample();
         check("access_psel", apb_uart_psel, 1'b1);
         check("access_penable", apb_uart_penable, 1'b1);
         check("access_paddr", apb_uart_paddr, e_addr);
         check("access_pwrite", apb_uart_pwrite, is_wr);
         check("access_pwdata", apb_uart_pwdata, e_wdata);
         check("access_tx_valid", tx_valid, 1'b0);
         check("access_rx_drop", rx_drop, rx_valid);
         step();
      end
      uart_apb_pready  = 1'b0;
      uart_apb_pslverr = 1'b0;
      uart_apb_prdata  = $urandom;
      rx_valid         = 1'b0;

      // RESP: drain the expected byte queue under a random tx_ready.
      cyc       = 0;
      hold_left = hold;
      while (exp_q.size() > 0 && cyc < 200) begin
         tx_ready = (hold_left > 0) ? 1'b0 : 1'($urandom_range(0, 1));
         drv      = ((drop_at == 3) && (cyc == 0)) ||
                    ((drop_at == 4) && (exp_q.size() == 1) && tx_ready);
         rx_valid = drv;
         rx_data  = 8'h57;
         sample();
         check("resp_psel", apb_uart_psel, 1'b0);
         check("resp_penable", apb_uart_penable, 1'b0);
         check("resp_tx_valid", tx_valid, 1'b1);
         check("resp_tx_data", tx_data, exp_q[0]);
         check("resp_rx_drop", rx_drop, drv);
         if (tx_valid && tx_ready) void'(exp_q.pop_front());
         step();
         hold_left--;
         cyc++;
      end
      if (exp_q.size() > 0) begin
         check("resp_budget_left", exp_q.size(), 0);
         exp_q.delete();
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      sample();
      check("post_tx_valid", tx_valid, 1'b0);
      check("post_busy", busy, 1'b0);
      step();
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int n;
      rst_apb_n        = 1'b0;
      rx_valid         = 1'b0;
      rx_data          = 8'h0;
      tx_ready         = 1'b0;
      uart_apb_prdata  = 32'h0;
      uart_apb_pready  = 1'b0;
      uart_apb_pslverr = 1'b0;

      // Reset state.
      sample();
      check("rst_psel", apb_uart_psel, 1'b0);
      check("rst_penable", apb_uart_penable, 1'b0);
      check("rst_pwrite", apb_uart_pwrite, 1'b0);
      check("rst_paddr", apb_uart_paddr, 12'h0);
      check("rst_pwdata", apb_uart_pwdata, 32'h0);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 8'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_rx_drop", rx_drop, 1'b0);
      step();
      step();
      rst_apb_n = 1'b1;
      step();

      // Directed: write, read with stalled transmitter, wait states, error.
      run_txn(1'b1, 16'h0004, 32'h12345678, 32'h0, 0, 1'b0, 0, 0, -1);
      run_txn(1'b0, 16'hF008, 32'h0, 32'h00000101, 0, 1'b0, 3, 0, -1);
      run_txn(1'b1, 16'h0123, 32'hDEADBEEF, 32'h0, 3, 1'b0, 0, 0, -1);
      run_txn(1'b1, 16'h0010, 32'hCAFEF00D, 32'h0, 1, 1'b1, 0, 2, -1);
      run_txn(1'b0, 16'hA5C3, 32'h0, 32'h89ABCDEF, 2, 1'b1, 1, 1, -1);
      run_txn(1'b0, 16'h0777, 32'h0, 32'h11223344, 0, 1'b0, 0, 4, -1);
      // Byte lands exactly on the timeout cycle: must continue the frame.
      run_txn(1'b1, 16'h0ABC, 32'h0BADF00D, 32'h0, 0, 1'b0, 0, 3, 2);

      // Timeout: 'W' 0x04 then silence.
      send_byte(8'h57, 0);
      send_byte(8'h04, 0);
      n = 0;
      while (n < 4 * TO) begin
         sample();
         check("to_psel", apb_uart_psel, 1'b0);
         if (frame_err) break;
         step();
         n++;
      end
      check("to_cycles_after_strobe", n + 1, TO);
      step();
      sample();
      check("to_pulse_width", frame_err, 1'b0);
      check("to_busy", busy, 1'b0);
      step();
      run_txn(1'b0, 16'h0004, 32'h0, 32'h5A5AA5A5, 0, 1'b0, 0, 0, -1);

      // Noise in IDLE.
      for (int i = 0; i < 3; i++) begin
         rx_valid = 1'b1;
         rx_data  = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h41;
         sample();
         check("noise_rx_drop", rx_drop, 1'b0);
         check("noise_psel", apb_uart_psel, 1'b0);
         step();
         rx_valid = 1'b0;
         sample();
         check("noise_busy", busy, 1'b0);
         check("noise_tx_valid", tx_valid, 1'b0);
         step();
      end

      // Reset in the middle of ACCESS.
      send_byte(8'h57, 0);
      send_byte(8'h40, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 4; i++) send_byte(8'h11 * (i + 1), 0);
      uart_apb_pready = 1'b0;
      sample();
      step();
      sample();
      check("mid_penable", apb_uart_penable, 1'b1);
      #1 rst_apb_n = 1'b0;
      #1;
      check("mid_rst_psel", apb_uart_psel, 1'b0);
      check("mid_rst_penable", apb_uart_penable, 1'b0);
      check("mid_rst_paddr", apb_uart_paddr, 12'h0);
      check("mid_rst_pwdata", apb_uart_pwdata, 32'h0);
      check("mid_rst_tx_valid", tx_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      step();
      step();
      rst_apb_n = 1'b1;
      step();
      run_txn(1'b1, 16'h0FFF, 32'hFFFFFFFF, 32'h0, 0, 1'b0, 0, 0, -1);

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         bit is_wr;
         int gap_idx;
         is_wr   = 1'($urandom_range(0, 1));
         gap_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, is_wr ? 6 : 2)) : -1;
         run_txn(is_wr, 16'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), gap_idx);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_apb_master.md
UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16'd65535, number of idle clk_apb cycles allowed between bytes of one frame before it is abandoned.
REQ-002 clk_apb  in  1  APB clock; all logic is on the rising edge.
REQ-003 rst_apb_n  in  1  reset; asynchronous and active-low.
REQ-004 rx_valid  in  1  single-cycle strobe marking a received UART byte; there is no backpressure.
REQ-005 rx_data  in  8  received byte, valid only when rx_valid=1.
REQ-006 tx_valid  out  1  response byte is available to the UART transmitter.
REQ-007 tx_data  out  8  response byte.
REQ-008 tx_ready  in  1  transmitter accepts tx_data when tx_valid=1 and tx_ready=1.
REQ-009 apb_uart_psel  out  1  APB select.
REQ-010 apb_uart_paddr  out  12  APB address.
REQ-011 apb_uart_penable  out  1  APB enable.
REQ-012 apb_uart_pwrite  out  1  APB write.
REQ-013 apb_uart_pwdata  out  32  APB write data.
REQ-014 uart_apb_prdata  in  32  APB read data.
REQ-015 uart_apb_pready  in  1  APB ready.
REQ-016 uart_apb_pslverr  in  1  APB error.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 frame_err  out  1  one-cycle pulse when a frame is abandoned on timeout.
REQ-019 rx_drop  out  1  one-cycle pulse when a byte arrives in SETUP, ACCESS or RESP and is discarded.

Function
REQ-020 Frame format:
- Write: 0x57 ('W'), ADDR_LO, ADDR_HI, D0, D1, D2, D3 (data LSB first).
- Read: 0x52 ('R'), ADDR_LO, ADDR_HI.
REQ-021 paddr SHALL be {ADDR_HI[3:0], ADDR_LO}; ADDR_HI[7:4] is ignored.
REQ-022 In IDLE, any rx byte other than 0x57 or 0x52 SHALL be ignored with no output activity.
REQ-023 FSM states: IDLE, ADDR0, ADDR1, DATA (2-bit byte index 0..3), SETUP, ACCESS, RESP.
REQ-024 FSM transitions:
- IDLE -> ADDR0 on a valid command byte.
- ADDR0 -> ADDR1 on the next byte.
- ADDR1 -> DATA on write, -> SETUP on read.
- DATA -> SETUP after D3.
- SETUP -> ACCESS unconditionally.
- ACCESS -> RESP in the cycle uart_apb_pready=1.
- RESP -> IDLE after the last response byte handshakes.
REQ-025 The cycle after the final frame byte strobes, SETUP SHALL drive psel=1, penable=0, with paddr, pwrite and pwdata stable.
REQ-026 ACCESS SHALL drive psel=1, penable=1, holding paddr, pwrite and pwdata, for as long as uart_apb_pready=0.
REQ-027 On the ACCESS cycle with pready=1, the block SHALL capture uart_apb_prdata (read) and uart_apb_pslverr; psel and penable SHALL be 0 on the next cycle.
REQ-028 APB outputs SHALL be zero outside SETUP and ACCESS; pwdata is 0 for reads.
REQ-029 RESP byte content:
- pslverr=1: a single byte 0x45 ('E').
- Write without error: a single byte 0x4B ('K').
- Read without error: 4 bytes of the captured prdata, LSB first.
REQ-030 RESP handshake: tx_valid SHALL be high throughout RESP; tx_data SHALL hold stable until tx_ready=1; the next byte SHALL be presented the following cycle.
REQ-031 In ADDR0, ADDR1 and DATA, a 16-bit idle counter SHALL clear on every rx_valid and increment otherwise.
REQ-032 Timeout: when the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE and pulse frame_err for one cycle; no APB access is made.
REQ-033 The counter SHALL not run in IDLE, SETUP, ACCESS or RESP.
REQ-034 If rx_valid coincides with the timeout cycle, the byte SHALL take priority: the counter clears and no timeout occurs.
REQ-035 Bytes arriving in SETUP, ACCESS or RESP SHALL be discarded and pulse rx_drop; the FSM is unaffected.
REQ-036 A byte arriving in the same cycle RESP -> IDLE occurs SHALL be dropped (rx_drop=1), not decoded.
REQ-037 Only one APB transfer is outstanding at a time; there is no command queueing.

Reset
REQ-038 Reset assertion SHALL immediately force:
- FSM=IDLE; idle counter, byte index and all captured data = 0.
- psel, penable, pwrite, tx_valid, busy, frame_err, rx_drop = 0.
- paddr=12'h0, pwdata=32'h0, tx_data=8'h0.
REQ-039 Reset mid-APB or mid-RESP SHALL abandon the transaction with no further output; after release the block accepts a new frame in IDLE.

Verification
REQ-040 Write: rx bytes 57 04 00 78 56 34 12, pready=1 -> SETUP one cycle after the 0x12 strobe with paddr=0x004, pwrite=1, pwdata=0x12345678; ACCESS next cycle; then tx 0x4B.
REQ-041 Read: rx 52 08 F0, prdata=0x00000101, pready=1 -> paddr=0x008, pwrite=0; tx 01 01 00 00 in order; tx_data stable across 3 cycles of tx_ready=0.
REQ-042 Wait states: pready low for 3 ACCESS cycles -> psel=penable=1 for 4 cycles, address and data constant, exactly one response.
REQ-043 Error: write frame with pslverr=1 at pready -> tx 0x45 only; a byte sent during ACCESS -> rx_drop pulse.
REQ-044 Timeout with TIMEOUT_CYCLES=16: rx 57 04, then silence -> frame_err 16 cycles after the 0x04 strobe, no psel; a following 52 04 00 completes normally.
REQ-045 Noise and reset: rx 00 FF 41 in IDLE -> no activity; rst_apb_n low during ACCESS -> psel=0 and tx_valid=0 immediately.
